// File: rtl/perm_chunk_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : perm_chunk_tx_if
//  Description : Bundle between a full-state producer and the chunked
//                permutation-state loader. The master side is the
//                serializer: it takes the state and drives the beats. The
//                slave side is whoever feeds it and consumes the beats.
//  Revision    : 1.0 - initial release
// ============================================================================
interface perm_chunk_tx_if #(
    parameter int CHUNK_W    = 200,
    parameter int NUM_CHUNKS = 8,
    parameter int IX_W       = 3
);
    localparam int STATE_W = CHUNK_W * NUM_CHUNKS;

    logic [STATE_W-1:0] state_in;
    logic               in_valid;
    logic               in_ready;
    logic               hold;
    logic [IX_W-1:0]    dix;
    logic [CHUNK_W-1:0] din;
    logic               pushin;
    logic               busy;
    logic               frame_done;

    modport master (
        input  state_in, in_valid, hold,
        output in_ready, dix, din, pushin, busy, frame_done
    );

    modport slave (
        output state_in, in_valid, hold,
        input  in_ready, dix, din, pushin, busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/perm_chunk_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : perm_chunk_tx
//  Description : Captures a full 1600-bit Keccak state in one handshake and
//                replays it as NUM_CHUNKS beats of CHUNK_W bits (dix/din/
//                pushin). A new frame can be taken on the cycle the last beat
//                fires, so frames run back to back. hold freezes emission.
//                2**IX_W must be at least NUM_CHUNKS.
//  Revision    : 1.0 - initial release
// ============================================================================
module perm_chunk_tx #(
    parameter int CHUNK_W    = 200,
    parameter int NUM_CHUNKS = 8,
    parameter int IX_W       = 3
) (
    input  wire logic        clk,
    input  wire logic        reset,
    perm_chunk_tx_if.master  bus
);
    localparam int STATE_W = CHUNK_W * NUM_CHUNKS;
    localparam logic [IX_W-1:0] c_last = IX_W'(NUM_CHUNKS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t             r_state;
    logic [IX_W-1:0]    r_cnt;
    logic [STATE_W-1:0] r_buf;

    logic               w_send;
    logic               w_last;
    logic               w_beat;
    logic               w_ready;
    logic               w_accept;
    logic [CHUNK_W-1:0] w_chunk [NUM_CHUNKS];

    // Slice the frame buffer into per-beat chunk views.
    for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
        assign w_chunk[gi] = r_buf[gi*CHUNK_W +: CHUNK_W];
    end

    assign w_send   = (r_state == ST_SEND);
    assign w_last   = (r_cnt == c_last);
    assign w_beat   = w_send && !bus.hold;
    // Ready is gated by reset so it reads low for the whole reset window;
    // in SEND it opens only on a last beat that actually fires.
    assign w_ready  = reset && (!w_send || (w_last && !bus.hold));
    assign w_accept = bus.in_valid && w_ready;

    // Frame FSM: load on accept, advance one chunk per unheld beat.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_buf   <= '0;
        end else if (w_accept) begin
            // Covers both the idle load and the reload on the last beat.
            r_buf   <= bus.state_in;
            r_cnt   <= '0;
            r_state <= ST_SEND;
        end else if (w_beat) begin
            if (w_last) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt + IX_W'(1);
            end
        end
    end

    // Beat outputs decode straight from state so they collapse with reset.
    assign bus.in_ready   = w_ready;
    assign bus.pushin     = w_beat;
    assign bus.busy       = w_send;
    assign bus.dix        = w_send ? r_cnt : '0;
    assign bus.din        = w_send ? w_chunk[r_cnt] : '0;
    assign bus.frame_done = w_beat && w_last;

endmodule
`default_nettype wire

// File: tb/tb_perm_chunk_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_perm_chunk_tx
//  Description : Bench for perm_chunk_tx. Table of hand-derived cycles for
//                single-frame and stall cases, directed multi-cycle
//                sequences, then random traffic, all against a beat-queue
//                reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perm_chunk_tx;
    localparam int CW = 200;
    localparam int NC = 8;
    localparam int SW = CW * NC;

    logic clk;
    logic reset;

    perm_chunk_tx_if bus ();

    perm_chunk_tx dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    typedef struct {
        logic       iv;
        logic       hold;
        logic       ready;
        logic       push;
        logic       busy;
        logic       done;
        logic [2:0] dix;
    } vec_t;

    typedef struct {
        logic [2:0]    dix;
        logic [CW-1:0] din;
        logic          last;
    } beat_t;

    vec_t  tbl [$];
    beat_t mq  [$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_push   = 0;
    int n_rdy    = 0;

    logic [SW-1:0] fa, fb, fc;

    function automatic logic [SW-1:0] mk_frame(input logic [7:0] base);
        logic [SW-1:0] f;
        for (int i = 0; i < NC; i++) f[i*CW +: CW] = {25{8'(base + 8'(i))}};
        return f;
    endfunction

    function automatic logic [SW-1:0] rnd_frame();
        logic [SW-1:0] f;
        for (int i = 0; i < SW/32; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    function automatic void add(input logic iv, input logic hold, input logic ready,
                                input logic push, input logic busy, input logic done,
                                input int dix);
        vec_t v;
        v.iv = iv; v.hold = hold; v.ready = ready; v.push = push;
        v.busy = busy; v.done = done; v.dix = 3'(dix);
        tbl.push_back(v);
    endfunction

    function automatic logic [206:0] dut_vec();
        return {bus.in_ready, bus.pushin, bus.busy, bus.frame_done, bus.dix, bus.din};
    endfunction

    task automatic chk(input string name, input logic [206:0] act, input logic [206:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    // Reference: an accepted frame becomes NC queued beats; each unheld cycle
    // emits the head. Called at the negedge with inputs stable; returns just
    // after the next rising edge.
    task automatic tick();
        logic          busy_e, push_e, done_e, rdy_e;
        logic [2:0]    dix_e;
        logic [CW-1:0] din_e;
        busy_e = (mq.size() != 0);
        push_e = busy_e && !bus.hold;
        dix_e  = 3'd0;
        din_e  = '0;
        done_e = 1'b0;
        if (busy_e) begin
            dix_e  = mq[0].dix;
            din_e  = mq[0].din;
            done_e = push_e && mq[0].last;
        end
        rdy_e = !busy_e || (mq.size() == 1 && push_e);
        chk("model", dut_vec(), {rdy_e, push_e, busy_e, done_e, dix_e, din_e});
        if (bus.pushin) n_push++;
        if (bus.in_ready && bus.busy) n_rdy++;
        if (push_e) mq.delete(0);
        if (bus.in_valid && rdy_e) begin
            for (int i = 0; i < NC; i++) begin
                beat_t b;
                b.dix  = 3'(i);
                b.din  = bus.state_in[i*CW +: CW];
                b.last = (i == NC - 1);
                mq.push_back(b);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic iv, input logic hold, input logic [SW-1:0] st);
        bus.in_valid = iv;
        bus.hold     = hold;
        bus.state_in = st;
        @(negedge clk);
        tick();
    endtask

    initial begin
        logic [CW-1:0] din_x;
        fa = mk_frame(8'h01);
        fb = mk_frame(8'h41);
        fc = mk_frame(8'h81);

        // Single frame: accept, eight beats, back to idle.
        add(1, 0, 1, 0, 0, 0, 0);
        for (int d = 0; d < 8; d++) add(0, 0, d == 7, 1, 1, d == 7, d);
        add(0, 0, 1, 0, 0, 0, 0);
        // Stall frame: hold ignored in idle, two held cycles at chunk 3.
        add(1, 1, 1, 0, 0, 0, 0);
        for (int d = 0; d < 3; d++) add(0, 0, 0, 1, 1, 0, d);
        add(0, 1, 0, 0, 1, 0, 3);
        add(0, 1, 0, 0, 1, 0, 3);
        for (int d = 3; d < 8; d++) add(0, 0, d == 7, 1, 1, d == 7, d);
        add(0, 0, 1, 0, 0, 0, 0);

        reset        = 1'b0;
        bus.in_valid = 1'b0;
        bus.hold     = 1'b0;
        bus.state_in = fa;
        #12;
        chk("reset", dut_vec(), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            bus.in_valid = tbl[i].iv;
            bus.hold     = tbl[i].hold;
            bus.state_in = fa;
            @(negedge clk);
            din_x = tbl[i].busy ? fa[int'(tbl[i].dix)*CW +: CW] : '0;
            chk("tbl", dut_vec(), {tbl[i].ready, tbl[i].push, tbl[i].busy,
                                   tbl[i].done, tbl[i].dix, din_x});
            tick();
        end

        // Back to back: B waits with valid high, taken on A's last beat.
        cyc(1, 0, fa);
        n_push = 0;
        n_rdy  = 0;
        for (int i = 0; i < 8; i++) cyc(1, 0, fb);
        chk("b2b_ready_cycles", 207'(n_rdy), 207'(1));
        for (int i = 0; i < 8; i++) cyc(0, 0, fb);
        chk("b2b_contig_beats", 207'(n_push), 207'(16));
        cyc(0, 0, fb);

        // Ignored input during beats 1..6.
        cyc(1, 0, fa);
        cyc(0, 0, fa);
        n_push = 0;
        for (int i = 0; i < 6; i++) cyc(1, 0, fc);
        cyc(0, 0, fc);
        cyc(0, 0, fc);
        cyc(0, 0, fc);
        chk("ignored_no_extra", 207'(n_push), 207'(7));

        // Hold on the last beat blocks accept; release fires beat and accept.
        cyc(1, 0, fa);
        for (int i = 0; i < 7; i++) cyc(0, 0, fa);
        cyc(1, 1, fb);
        cyc(1, 1, fb);
        cyc(1, 0, fb);
        for (int i = 0; i < 8; i++) cyc(0, 0, fb);
        cyc(0, 0, fb);

        // Reset mid-frame at dix 4.
        cyc(1, 0, fa);
        for (int i = 0; i < 4; i++) cyc(0, 0, fa);
        chk("pre_rst_dix", 207'(bus.dix), 207'(4));
        #2;
        reset = 1'b0;
        #1;
        chk("rst_mid_async", dut_vec(), '0);
        mq.delete();
        @(posedge clk);
        #1;
        chk("rst_mid_held", dut_vec(), '0);
        reset = 1'b1;
        n_push = 0;
        for (int i = 0; i < 3; i++) cyc(0, 0, fa);
        chk("rst_no_resume", 207'(n_push), 207'(0));
        cyc(1, 0, fb);
        for (int i = 0; i < 9; i++) cyc(0, 0, fb);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 3) == 0, ($urandom % 4) == 0, rnd_frame());
        end
        for (int i = 0; i < 10; i++) cyc(0, 0, fa);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
